vga_layer_compositor: RTL and testbench
=======================================

Name: vga_layer_compositor

Overview:
- Parametrised VGA pixel-pipeline stage that merges a background stream and NUM_LAYERS overlay streams into one 12-bit RGB output.
- Replaces the hand-chained per-overlay stages (grid, edges, score, menu) with a single priority compositor.
- Adds frame-synchronised layer enables, blank forcing, a frame counter and per-layer hit flags.
- Sits between the timing/RGB-controller front end and the board {r,g,b}/hsync/vsync pins, in the clk_65Mhz domain.

Parameters:
- NUM_LAYERS, 4, number of overlay layers; 1..8. Index NUM_LAYERS-1 has the highest priority.
- PIPE_STAGES, 2, total latency in clk cycles from inputs to outputs; 1..8.
- FRAME_W, 16, width of the frame counter.
- LAYER_EN_RST, all ones (NUM_LAYERS bits), reset value of the shadow enable register.

Ports:
- clk  in  1  pixel clock, clk_65Mhz.
- rst  in  1  asynchronous reset, active-high.
- hcount_in  in  16  horizontal pixel count.
- vcount_in  in  16  vertical line count.
- hsync_in, vsync_in  in  1 each  sync pulses, active-high.
- hblnk_in, vblnk_in  in  1 each  blanking flags.
- rgb_bg_in  in  12  background pixel colour.
- layer_rgb_in  in  12*NUM_LAYERS  overlay colours; layer i is at bits [12i+11:12i].
- layer_valid_in  in  NUM_LAYERS  layer i covers the current pixel.
- layer_en_in  in  NUM_LAYERS  requested layer enables; sampled only at frame start.
- hcount_out, vcount_out  out  16 each  hcount_in/vcount_in delayed by PIPE_STAGES cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed by PIPE_STAGES cycles.
- rgb_out  out  12  composited pixel colour.
- layer_hit_out  out  NUM_LAYERS  per-layer valid AND shadow enable, aligned with rgb_out.
- frame_cnt  out  FRAME_W  number of completed frame starts.

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0.
  - The pipeline registers, the previous-vsync register and frame_cnt go to 0.
  - en_shadow goes to LAYER_EN_RST.
- Frame-start detection: vs_q registers vsync_in every cycle; a frame start is vsync_in=1 and vs_q=0.
- Shadow enable:
  - On a frame start, en_shadow <= layer_en_in, effective from the next cycle.
  - layer_en_in changes made mid-frame have no effect until the next frame start.
- Frame counter: frame_cnt increments by 1 on each frame start and wraps modulo 2^FRAME_W (all ones to 0).
- Stage 1 (combinational on the inputs, registered at the clk edge):
  - hit[i] = layer_valid_in[i] & en_shadow[i].
  - Winner is the highest i with hit[i]=1.
  - pixel = layer_rgb_in of the winner; pixel = rgb_bg_in if no hit is set.
  - If hblnk_in or vblnk_in is set, pixel = 12'h000 regardless of the hits. layer_hit_out still reports the hits.
  - At the frame-start cycle, the compare uses the old en_shadow (the value before the update).
- Stages 2..PIPE_STAGES:
  - Pure delay registers for pixel, hit, counts, syncs and blanks, all delayed identically.
  - Output latency is exactly PIPE_STAGES cycles for every output except frame_cnt.
  - frame_cnt updates 1 cycle after the frame-start input cycle.
- Simultaneous events: a hit on several layers resolves strictly by index (highest index wins).
- Reset mid-frame: the pipeline empties to 0 immediately. The first frame start after reset is counted as frame 1.
- There is no back-pressure; a new pixel is accepted every cycle.

Optional Feature:
- Macro: LAYER_BLEND_EN.
- When defined:
  - Extra input port layer_blend_in, NUM_LAYERS bits.
  - If the winning layer w has its blend bit set, each 4-bit channel of the pixel is (winner_ch + below_ch) >> 1, with a 5-bit sum and floor rounding.
  - below is the colour the composite would have with layer w removed: the next-highest hit layer, or rgb_bg_in if none.
  - Blank forcing still overrides the blended value.
  - Latency is unchanged; the blend is computed inside stage 1.
- When not defined: the port is absent and the winner's colour passes through unmodified.

Test Plan:
- Reset: assert rst with arbitrary inputs -> all outputs 0 and frame_cnt=0. Release rst; bg=12'h123, no valid, blanks=0 -> rgb_out=12'h123 exactly PIPE_STAGES=2 cycles later.
- Priority: valid=4'b0101, layer0=12'hF00, layer2=12'h0F0 -> rgb_out=12'h0F0 and layer_hit_out=4'b0101. Then valid=4'b0001 -> rgb_out=12'hF00.
- Shadow timing: change layer_en_in from 4'hF to 4'h0 mid-frame with valid=4'hF -> output unchanged until the vsync rising edge. The first pixel after that edge shows bg, and layer_hit_out=0.
- Blanking and alignment: pulse hblnk_in for 3 cycles at hcount=1024 -> rgb_out=0 for exactly 3 cycles, aligned with hblnk_out and with hcount_out=1024..1026.
- Frame counter wrap: FRAME_W=4, 17 vsync rising edges -> frame_cnt counts 1..15, then 0, then 1. A vsync held high for 10 cycles counts once.
- LAYER_BLEND_EN: bg=12'h000, layer1=12'hFFF with blend set and valid -> rgb_out=12'h777. With layer0=12'h222 also valid -> rgb_out=12'h888.

Source files
------------

// File: rtl/vga_layer_compositor_if.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor_if
//   Pixel-stream bundle around the VGA layer compositor: the incoming timing
//   (counts, syncs, blanks), the background colour, the overlay layers, and
//   the composited, delayed stream going out to the board pins.
//
//   Parameters : NUM_LAYERS (overlay count), FRAME_W (frame counter width).
//   Modports   : master - the front end that drives the *_in signals and
//                         observes the *_out signals.
//                slave  - the compositor itself.
//   Optional   : LAYER_BLEND_EN adds layer_blend_in (per-layer 50 % blend).
// ---------------------------------------------------------------------------
interface vga_layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int FRAME_W    = 16
);
  // Incoming pixel stream
  logic [15:0]              hcount_in;
  logic [15:0]              vcount_in;
  logic                     hsync_in;
  logic                     vsync_in;
  logic                     hblnk_in;
  logic                     vblnk_in;
  logic [11:0]              rgb_bg_in;
  logic [12*NUM_LAYERS-1:0] layer_rgb_in;
  logic [NUM_LAYERS-1:0]    layer_valid_in;
  logic [NUM_LAYERS-1:0]    layer_en_in;
`ifdef LAYER_BLEND_EN
  logic [NUM_LAYERS-1:0]    layer_blend_in;
`endif

  // Outgoing pixel stream
  logic [15:0]              hcount_out;
  logic [15:0]              vcount_out;
  logic                     hsync_out;
  logic                     vsync_out;
  logic                     hblnk_out;
  logic                     vblnk_out;
  logic [11:0]              rgb_out;
  logic [NUM_LAYERS-1:0]    layer_hit_out;
  logic [FRAME_W-1:0]       frame_cnt;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_bg_in, layer_rgb_in, layer_valid_in, layer_en_in,
`ifdef LAYER_BLEND_EN
    output layer_blend_in,
`endif
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out, layer_hit_out, frame_cnt
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_bg_in, layer_rgb_in, layer_valid_in, layer_en_in,
`ifdef LAYER_BLEND_EN
    input  layer_blend_in,
`endif
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out, layer_hit_out, frame_cnt
  );
endinterface

// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
//   Priority compositor for the VGA pixel pipeline (clk_65Mhz domain).
//   Merges a background colour and NUM_LAYERS overlay layers into a single
//   12-bit RGB pixel; the highest-indexed covering, enabled layer wins.
//   Layer enables are shadowed and only change at a frame start (rising
//   vsync_in), so an overlay never switches on or off mid-frame.
//
//   Ports:
//     clk  - pixel clock
//     rst  - asynchronous reset, active-high
//     bus  - vga_layer_compositor_if.slave:
//              in : hcount/vcount, hsync/vsync, hblnk/vblnk, rgb_bg,
//                   layer_rgb (12 bits per layer), layer_valid, layer_en
//              out: same timing delayed PIPE_STAGES cycles, rgb_out,
//                   layer_hit_out (valid & shadow enable), frame_cnt
//
//   Parameters: NUM_LAYERS (1..8), PIPE_STAGES (1..8), FRAME_W,
//               LAYER_EN_RST (reset value of the shadow enables).
//
//   Optional feature, macro LAYER_BLEND_EN: adds bus.layer_blend_in. A
//   winning layer with its blend bit set is averaged per 4-bit channel with
//   the colour that would show through without it. Latency is unchanged.
// ---------------------------------------------------------------------------
module vga_layer_compositor #(
  parameter int                    NUM_LAYERS   = 4,
  parameter int                    PIPE_STAGES  = 2,
  parameter int                    FRAME_W      = 16,
  parameter logic [NUM_LAYERS-1:0] LAYER_EN_RST = {NUM_LAYERS{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_layer_compositor_if.slave bus
);

  // Everything that travels down the delay line together.
  typedef struct packed {
    logic [15:0]           hcount;
    logic [15:0]           vcount;
    logic                  hsync;
    logic                  vsync;
    logic                  hblnk;
    logic                  vblnk;
    logic [11:0]           rgb;
    logic [NUM_LAYERS-1:0] hit;
  } pix_t;

  // -------------------------------------------------------------------------
  // Layer unpacking
  // -------------------------------------------------------------------------
  logic [11:0] layer_rgb [NUM_LAYERS];

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
    assign layer_rgb[gi] = bus.layer_rgb_in[12*gi +: 12];
  end

  // -------------------------------------------------------------------------
  // Frame start detection, shadow enables, frame counter
  // -------------------------------------------------------------------------
  logic                  vs_q_reg;
  logic                  frame_start;
  logic [NUM_LAYERS-1:0] en_shadow_reg;
  logic [FRAME_W-1:0]    frame_cnt_reg;

  assign frame_start = bus.vsync_in & ~vs_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q_reg      <= 1'b0;
      en_shadow_reg <= LAYER_EN_RST;
      frame_cnt_reg <= '0;
    end else begin
      vs_q_reg <= bus.vsync_in;
      if (frame_start) begin
        en_shadow_reg <= bus.layer_en_in;
        frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: priority select
  // The hit test deliberately uses the registered shadow, so on the
  // frame-start cycle itself the previous frame's enables still apply.
  // -------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] hit;
  logic [11:0]           top_rgb;
  logic [11:0]           pixel;

  assign hit = bus.layer_valid_in & en_shadow_reg;

`ifdef LAYER_BLEND_EN
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [11:0]      below_rgb;
  logic [IDX_W-1:0] top_idx;
  logic             any_hit;

  // Floor average of two 4-bit channels through a 5-bit sum.
  function automatic logic [3:0] avg4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[4:1];
  endfunction
`endif

  // Ascending scan: each later hit overrides the earlier one, so the last
  // assignment is the highest-index hit. The colour it displaced is exactly
  // what shows through with the winner removed.
  always_comb begin
    top_rgb = bus.rgb_bg_in;
`ifdef LAYER_BLEND_EN
    below_rgb = bus.rgb_bg_in;
    top_idx   = '0;
    any_hit   = 1'b0;
`endif
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (hit[i]) begin
`ifdef LAYER_BLEND_EN
        below_rgb = top_rgb;
        top_idx   = IDX_W'(i);
        any_hit   = 1'b1;
`endif
        top_rgb = layer_rgb[i];
      end
    end
  end

  always_comb begin
    pixel = top_rgb;
`ifdef LAYER_BLEND_EN
    if (any_hit && bus.layer_blend_in[top_idx]) begin
      pixel = {avg4(top_rgb[11:8], below_rgb[11:8]),
               avg4(top_rgb[7:4],  below_rgb[7:4]),
               avg4(top_rgb[3:0],  below_rgb[3:0])};
    end
`endif
    // Blanking always wins, but the hit flags below still report coverage.
    if (bus.hblnk_in || bus.vblnk_in) begin
      pixel = 12'h000;
    end
  end

  pix_t stage1_next;

  always_comb begin
    stage1_next        = '0;
    stage1_next.hcount = bus.hcount_in;
    stage1_next.vcount = bus.vcount_in;
    stage1_next.hsync  = bus.hsync_in;
    stage1_next.vsync  = bus.vsync_in;
    stage1_next.hblnk  = bus.hblnk_in;
    stage1_next.vblnk  = bus.vblnk_in;
    stage1_next.rgb    = pixel;
    stage1_next.hit    = hit;
  end

  // -------------------------------------------------------------------------
  // Stages 1..PIPE_STAGES: stage 1 captures the composite, the rest are a
  // plain delay line so every output leaves with identical latency.
  // -------------------------------------------------------------------------
  pix_t pipe_reg [PIPE_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pipe_reg[s] <= '0;
      end
    end else begin
      pipe_reg[0] <= stage1_next;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pipe_reg[s] <= pipe_reg[s-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.hcount_out    = pipe_reg[PIPE_STAGES-1].hcount;
  assign bus.vcount_out    = pipe_reg[PIPE_STAGES-1].vcount;
  assign bus.hsync_out     = pipe_reg[PIPE_STAGES-1].hsync;
  assign bus.vsync_out     = pipe_reg[PIPE_STAGES-1].vsync;
  assign bus.hblnk_out     = pipe_reg[PIPE_STAGES-1].hblnk;
  assign bus.vblnk_out     = pipe_reg[PIPE_STAGES-1].vblnk;
  assign bus.rgb_out       = pipe_reg[PIPE_STAGES-1].rgb;
  assign bus.layer_hit_out = pipe_reg[PIPE_STAGES-1].hit;
  assign bus.frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_layer_compositor
//   Drives directed and random pixel streams into vga_layer_compositor.
//   For every driven pixel a reference model predicts the output, pushes it
//   into a queue, and an independent monitor compares it when it emerges.
// ---------------------------------------------------------------------------
module tb_vga_layer_compositor;
  localparam int NL = 4;
  localparam int PS = 2;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_layer_compositor_if #(.NUM_LAYERS(NL), .FRAME_W(FW)) bus ();

  vga_layer_compositor #(
    .NUM_LAYERS  (NL),
    .PIPE_STAGES (PS),
    .FRAME_W     (FW),
    .LAYER_EN_RST(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0]      h;
    logic [15:0]      v;
    logic             hs;
    logic             vs;
    logic             hb;
    logic             vb;
    logic [11:0]      bg;
    logic [12*NL-1:0] rgbs;
    logic [NL-1:0]    valid;
    logic [NL-1:0]    en;
    logic [NL-1:0]    blend;
  } stim_t;

  typedef struct {
    int            cyc;
    logic [35:0]   timing;
    logic [11:0]   rgb;
    logic [NL-1:0] hit;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [FW-1:0] fc;
  } fc_t;

  exp_t exp_q[$];
  fc_t  fc_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic [NL-1:0] m_en      = '1;
  logic          m_prev_vs = 1'b0;
  int            m_fc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic apply(input stim_t s);
    bus.hcount_in      = s.h;
    bus.vcount_in      = s.v;
    bus.hsync_in       = s.hs;
    bus.vsync_in       = s.vs;
    bus.hblnk_in       = s.hb;
    bus.vblnk_in       = s.vb;
    bus.rgb_bg_in      = s.bg;
    bus.layer_rgb_in   = s.rgbs;
    bus.layer_valid_in = s.valid;
    bus.layer_en_in    = s.en;
`ifdef LAYER_BLEND_EN
    bus.layer_blend_in = s.blend;
`endif
  endtask

  // Apply one pixel, predict its output, then advance one clock.
  task automatic drive(input stim_t s);
    exp_t          e;
    fc_t           f;
    logic [NL-1:0] hits;
    logic [11:0]   pix;
    int            w;
    apply(s);
    hits = s.valid & m_en;
    w = -1;
    for (int i = NL - 1; i >= 0; i--) begin
      if (hits[i] && w < 0) w = i;
    end
    pix = (w < 0) ? s.bg : s.rgbs[12*w +: 12];
`ifdef LAYER_BLEND_EN
    if (w >= 0 && s.blend[w]) begin
      logic [11:0] below;
      below = s.bg;
      for (int j = w - 1; j >= 0; j--) begin
        if (hits[j]) begin
          below = s.rgbs[12*j +: 12];
          break;
        end
      end
      for (int c = 0; c < 3; c++) begin
        pix[4*c +: 4] = 4'((int'(pix[4*c +: 4]) + int'(below[4*c +: 4])) / 2);
      end
    end
`endif
    if (s.hb || s.vb) pix = 12'h000;
    e.cyc    = cyc;
    e.timing = {s.h, s.v, s.hs, s.vs, s.hb, s.vb};
    e.rgb    = pix;
    e.hit    = hits;
    exp_q.push_back(e);
    if (s.vs && !m_prev_vs) begin
      m_en = s.en;
      m_fc = (m_fc + 1) % (1 << FW);
    end
    m_prev_vs = s.vs;
    f.cyc = cyc;
    f.fc  = FW'(m_fc);
    fc_q.push_back(f);
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_stim(inout stim_t s);
    s.h  = s.h + 16'd1;
    s.v  = 16'($urandom_range(0, 767));
    s.hs = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) s.vs = ~s.vs;
    s.hb = ($urandom_range(0, 5) == 0);
    s.vb = ($urandom_range(0, 9) == 0);
    s.bg = 12'($urandom);
    for (int i = 0; i < NL; i++) s.rgbs[12*i +: 12] = 12'($urandom);
    s.valid = NL'($urandom);
    s.en    = NL'($urandom);
    s.blend = NL'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"},    64'(bus.rgb_out), 64'd0);
    check({tag, "_hit"},    64'(bus.layer_hit_out), 64'd0);
    check({tag, "_timing"}, 64'({bus.hcount_out, bus.vcount_out, bus.hsync_out,
                                 bus.vsync_out, bus.hblnk_out, bus.vblnk_out}), 64'd0);
    check({tag, "_frame"},  64'(bus.frame_cnt), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    fc_q.delete();
    m_en      = '1;
    m_prev_vs = 1'b0;
    m_fc      = 0;
  endtask

  // Monitor: compares each queued prediction when its pixel reaches the pins.
  exp_t me;
  fc_t  mf;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc + PS == cyc) begin
        me = exp_q.pop_front();
        $display("pixel issued@%0d rgb=%h hit=%b", me.cyc, bus.rgb_out, bus.layer_hit_out);
        check("rgb_out", 64'(bus.rgb_out), 64'(me.rgb));
        check("layer_hit_out", 64'(bus.layer_hit_out), 64'(me.hit));
        check("timing_out", 64'({bus.hcount_out, bus.vcount_out, bus.hsync_out,
                                 bus.vsync_out, bus.hblnk_out, bus.vblnk_out}), 64'(me.timing));
      end
      if (fc_q.size() > 0 && fc_q[0].cyc + 1 == cyc) begin
        mf = fc_q.pop_front();
        check("frame_cnt", 64'(bus.frame_cnt), 64'(mf.fc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = '0;
    randomize_stim(s);
    apply(s);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Release reset; background only.
    s = '0;
    s.en = 4'hF;
    s.bg = 12'h123;
    rst = 1'b0;
    model_reset();
    repeat (4) drive(s);

    // Priority: layer 2 beats layer 0, then layer 0 alone.
    s.rgbs = {12'h00F, 12'h0F0, 12'h555, 12'hF00};
    s.valid = 4'b0101;
    repeat (3) drive(s);
    s.valid = 4'b0001;
    repeat (3) drive(s);

    // Shadow timing: mid-frame disable waits for the vsync rising edge.
    s.rgbs = {12'hABC, 12'h0F0, 12'h555, 12'hF00};
    s.valid = 4'hF;
    s.en = 4'h0;
    repeat (4) drive(s);
    s.vs = 1'b1;
    repeat (4) drive(s);
    s.vs = 1'b0;
    s.en = 4'hF;
    repeat (2) drive(s);

    // Blanking: three blanked pixels at hcount 1024..1026.
    s.valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      s.h  = 16'(1024 + i);
      s.hb = (i < 3);
      drive(s);
    end
    s.hb = 1'b0;

    // Frame counter wrap: 17 single-cycle vsync pulses.
    for (int i = 0; i < 17; i++) begin
      s.vs = 1'b1;
      drive(s);
      s.vs = 1'b0;
      drive(s);
    end
    // A long vsync counts once.
    s.vs = 1'b1;
    repeat (10) drive(s);
    s.vs = 1'b0;
    repeat (3) drive(s);

`ifdef LAYER_BLEND_EN
    // Blend: layer1 over background, then over layer0.
    s.vs = 1'b1;
    drive(s);
    s.vs = 1'b0;
    s.bg = 12'h000;
    s.rgbs = {12'h000, 12'h000, 12'hFFF, 12'h222};
    s.blend = 4'b0010;
    s.valid = 4'b0010;
    repeat (3) drive(s);
    s.valid = 4'b0011;
    repeat (3) drive(s);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      randomize_stim(s);
      drive(s);
    end

    // Asynchronous reset mid-frame empties the pipeline immediately.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      randomize_stim(s);
      drive(s);
    end

    repeat (PS + 2) @(negedge clk);
    check("drain_pixels", 64'(exp_q.size()), 64'd0);
    check("drain_frames", 64'(fc_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
